// File: rtl/s_cycle_cpu.sv
// rtl/s_cycle_cpu.sv - single-cycle MIPS subset CPU; branch/jump support guarded by S_CYCLE_CPU_BRANCH_EN
module s_cycle_cpu_im (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [9:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [9:0]  raddr_i,
  output logic [31:0] rdata_o
);
  logic [31:0] ins_memory [0:1023];

  // Optional loader port; the image is normally placed hierarchically.
  always_ff @(posedge clk_i) begin
    if (we_i) ins_memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = ins_memory[raddr_i];
endmodule

module s_cycle_cpu_gpr (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] gp_registers [0:31];

  // Synchronous write port; register 0 is never written.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) gp_registers[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : gp_registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : gp_registers[raddr2_i];
endmodule

module s_cycle_cpu_dm (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [9:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] data_memory [0:1023];

  // Word store on the same edge as the register write.
  always_ff @(posedge clk_i) begin
    if (we_i) data_memory[addr_i] <= wdata_i;
  end

  assign rdata_o = data_memory[addr_i];
endmodule

module s_cycle_cpu (
  input logic clock,
  input logic reset
);
  logic [31:0] pc_q, pc_d, pc_plus4, next_pc;
  logic [31:0] instr, rs_val, rt_val, dm_rdata, mem_addr;
  logic [31:0] sext_imm, zext_imm, wr_data;
  logic [4:0]  wr_addr;
  logic        wr_en, dm_we;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        unused_bits;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};
  assign zext_imm = {16'h0, instr[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs_val + sext_imm;
  // The PC lives in the 4 KB instruction space, so high bits are dropped.
  assign pc_d     = {20'h0, next_pc[11:0]};
  assign unused_bits = ^{pc_plus4[31:12], next_pc[31:12], mem_addr[31:12], mem_addr[1:0]};

  s_cycle_cpu_im IM (
    .clk_i   (clock),
    .we_i    (1'b0),
    .waddr_i (10'd0),
    .wdata_i (32'h0),
    .raddr_i (pc_q[11:2]),
    .rdata_o (instr)
  );

  s_cycle_cpu_gpr GPR (
    .clk_i    (clock),
    .we_i     (wr_en & reset),
    .waddr_i  (wr_addr),
    .wdata_i  (wr_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val)
  );

  s_cycle_cpu_dm DM (
    .clk_i   (clock),
    .we_i    (dm_we & reset),
    .addr_i  (mem_addr[11:2]),
    .wdata_i (rt_val),
    .rdata_o (dm_rdata)
  );

  // PC register; reset forces it to 0 without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= 32'h0;
    else        pc_q <= pc_d;
  end

  // Decode and execute; unrecognised encodings fall through as no-ops.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = 32'h0;
    dm_we   = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      6'h00: begin
        wr_en = 1'b1;
        case (funct)
          6'h20, 6'h21: wr_data = rs_val + rt_val;
          6'h22, 6'h23: wr_data = rs_val - rt_val;
          6'h24:        wr_data = rs_val & rt_val;
          6'h25:        wr_data = rs_val | rt_val;
          6'h26:        wr_data = rs_val ^ rt_val;
          6'h27:        wr_data = ~(rs_val | rt_val);
          6'h2A:        wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B:        wr_data = {31'h0, rs_val < rt_val};
          6'h00:        wr_data = rt_val << shamt;
          6'h02:        wr_data = rt_val >> shamt;
          6'h03:        wr_data = $unsigned($signed(rt_val) >>> shamt);
          6'h04:        wr_data = rt_val << rs_val[4:0];
          6'h06:        wr_data = rt_val >> rs_val[4:0];
          6'h07:        wr_data = $unsigned($signed(rt_val) >>> rs_val[4:0]);
          default:      wr_en   = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + sext_imm; end
      6'h0C:        begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & zext_imm; end
      6'h0D:        begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | zext_imm; end
      6'h0E:        begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ zext_imm; end
      6'h0F:        begin wr_en = 1'b1; wr_addr = rt; wr_data = {instr[15:0], 16'h0}; end
      6'h0A:        begin
        wr_en = 1'b1; wr_addr = rt;
        wr_data = {31'h0, $signed(rs_val) < $signed(sext_imm)};
      end
      6'h23:        begin wr_en = 1'b1; wr_addr = rt; wr_data = dm_rdata; end
      6'h2B:        dm_we = 1'b1;
`ifdef S_CYCLE_CPU_BRANCH_EN
      6'h04:        if (rs_val == rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
      6'h05:        if (rs_val != rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
      6'h02:        next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
`else
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_s_cycle_cpu.sv
// tb/tb_s_cycle_cpu.sv - directed vector bench for s_cycle_cpu
`timescale 1ps/1ps
module tb_s_cycle_cpu;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [24];

  s_cycle_cpu dut (.clock(clock), .reset(reset));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 1024; i++) begin
      dut.IM.ins_memory[i] = 32'h0;
      dut.DM.data_memory[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.GPR.gp_registers[i] = 32'h0;
  endtask

  task automatic enter_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic leave_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // rs = $1 = a, rt = $2 = b, result in $3 (R-type rd, I-type rt)
    vecs[0]  = '{32'h00221821, 32'hFFFFFFFF, 32'h00000002, 32'h00000001}; // addu wrap
    vecs[1]  = '{32'h00221822, 32'h00000005, 32'h00000007, 32'hFFFFFFFE}; // sub
    vecs[2]  = '{32'h00221824, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000}; // and
    vecs[3]  = '{32'h00221825, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0}; // or
    vecs[4]  = '{32'h00221826, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0}; // xor
    vecs[5]  = '{32'h00221827, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000}; // nor
    vecs[6]  = '{32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}; // slt
    vecs[7]  = '{32'h0022182B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}; // sltu
    vecs[8]  = '{32'h00221900, 32'h00000000, 32'h8000000F, 32'h000000F0}; // sll 4
    vecs[9]  = '{32'h00221902, 32'h00000000, 32'h80000000, 32'h08000000}; // srl 4
    vecs[10] = '{32'h00221903, 32'h00000000, 32'h80000000, 32'hF8000000}; // sra 4
    vecs[11] = '{32'h00221804, 32'h00000024, 32'h00000001, 32'h00000010}; // sllv rs[4:0]=4
    vecs[12] = '{32'h00221806, 32'h00000004, 32'h80000000, 32'h08000000}; // srlv
    vecs[13] = '{32'h00221807, 32'h00000004, 32'h80000000, 32'hF8000000}; // srav
    vecs[14] = '{32'h2423FFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF}; // addiu -1
    vecs[15] = '{32'h20230001, 32'h7FFFFFFF, 32'h00000000, 32'h80000000}; // addi no trap
    vecs[16] = '{32'h3023FFFF, 32'hFFFF1234, 32'h00000000, 32'h00001234}; // andi
    vecs[17] = '{32'h34238000, 32'h00010000, 32'h00000000, 32'h00018000}; // ori zext
    vecs[18] = '{32'h3823FFFF, 32'hFFFF0000, 32'h00000000, 32'hFFFFFFFF}; // xori
    vecs[19] = '{32'h3C231234, 32'h00000000, 32'h00000000, 32'h12340000}; // lui
    vecs[20] = '{32'h2823FFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000001}; // slti true
    vecs[21] = '{32'h28230005, 32'h00000005, 32'h00000000, 32'h00000000}; // slti equal
    vecs[22] = '{32'h00221801, 32'h00000001, 32'h00000002, 32'hDEADBEEF}; // bad funct
    vecs[23] = '{32'hFC230000, 32'h00000001, 32'h00000002, 32'hDEADBEEF}; // bad opcode

    // Reference program: reset low for 10 ps, check at 100 ps
    reset = 1'b0;
    clear_all();
    dut.GPR.gp_registers[2] = 32'hFFFFFFFF;
    dut.IM.ins_memory[0] = 32'h2001000A;
    dut.IM.ins_memory[1] = 32'h00221807;
    #1;
    check("reset_pc", dut.pc_q, 32'h0);
    #9 reset = 1'b1;
    #90;
    check("ref_gpr1", dut.GPR.gp_registers[1], 32'd10);
    check("ref_gpr2", dut.GPR.gp_registers[2], 32'hFFFFFFFF);
    check("ref_gpr3", dut.GPR.gp_registers[3], 32'hFFFFFFFF);

    // Single-instruction ALU vectors
    for (int i = 0; i < 24; i++) begin
      enter_reset();
      clear_all();
      dut.IM.ins_memory[0] = vecs[i].instr;
      dut.GPR.gp_registers[1] = vecs[i].a;
      dut.GPR.gp_registers[2] = vecs[i].b;
      dut.GPR.gp_registers[3] = 32'hDEADBEEF;
      leave_reset();
      @(negedge clock);
      check($sformatf("vec%0d", i), dut.GPR.gp_registers[3], vecs[i].exp);
    end

    // Load / modify / store
    enter_reset();
    clear_all();
    dut.DM.data_memory[0] = 32'd1000;
    dut.IM.ins_memory[0] = 32'h8C040000;
    dut.IM.ins_memory[1] = 32'h2485FFFF;
    dut.IM.ins_memory[2] = 32'hAC050004;
    leave_reset();
    repeat (3) @(negedge clock);
    check("lw_gpr4", dut.GPR.gp_registers[4], 32'd1000);
    check("addiu_gpr5", dut.GPR.gp_registers[5], 32'd999);
    check("sw_dm1", dut.DM.data_memory[1], 32'd999);
    check("pc_after3", dut.pc_q, 32'd12);

    // $0 is hardwired; lui/ori builds a constant
    enter_reset();
    clear_all();
    dut.IM.ins_memory[0] = 32'h20000005;
    dut.IM.ins_memory[1] = 32'h3C061234;
    dut.IM.ins_memory[2] = 32'h34C65678;
    leave_reset();
    repeat (3) @(negedge clock);
    check("gpr0_zero", dut.GPR.gp_registers[0], 32'h0);
    check("lui_ori", dut.GPR.gp_registers[6], 32'h12345678);

    // Mid-program reset: PC clears at once, state survives, restart at IM[0]
    enter_reset();
    clear_all();
    dut.DM.data_memory[0] = 32'd1000;
    dut.IM.ins_memory[0] = 32'h8C040000;
    dut.IM.ins_memory[1] = 32'h2485FFFF;
    dut.IM.ins_memory[2] = 32'hAC050004;
    leave_reset();
    repeat (2) @(negedge clock);
    check("mid_pc_before", dut.pc_q, 32'd8);
    #2 reset = 1'b0;
    #1;
    check("mid_pc_async", dut.pc_q, 32'h0);
    check("mid_gpr4", dut.GPR.gp_registers[4], 32'd1000);
    check("mid_gpr5", dut.GPR.gp_registers[5], 32'd999);
    dut.DM.data_memory[0] = 32'd2000;
    @(negedge clock);
    check("held_pc", dut.pc_q, 32'h0);
    check("held_dm1", dut.DM.data_memory[1], 32'h0);
    check("held_gpr4", dut.GPR.gp_registers[4], 32'd1000);
    reset = 1'b1;
    @(negedge clock);
    check("restart_gpr4", dut.GPR.gp_registers[4], 32'd2000);
    check("restart_pc", dut.pc_q, 32'd4);

    // beq $0,$0,+1 at PC 0
    enter_reset();
    clear_all();
    dut.IM.ins_memory[0] = 32'h10000001;
    leave_reset();
    @(negedge clock);
`ifdef S_CYCLE_CPU_BRANCH_EN
    check("beq_next_pc", dut.pc_q, 32'd8);
`else
    check("beq_next_pc", dut.pc_q, 32'd4);
`endif

    // PC wraps at the 4 KB boundary
    enter_reset();
    clear_all();
    leave_reset();
    repeat (1023) @(negedge clock);
    check("pc_top", dut.pc_q, 32'h00000FFC);
    @(negedge clock);
    check("pc_wrap", dut.pc_q, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
